a2d_sched: RTL and testbench

Round-robin scheduler that shares the single A2D SPI transaction engine between four conversion requesters (throttle, battery, steering, torque). Pending requests are latched, one requester is granted at a time, and the two-transaction A2D conversion is sequenced: a command frame, then a read frame. The 12-bit result is returned to the granted requester with a one-cycle valid strobe. The block sits between the sensor-consuming logic and the SPI master, and no other block drives the SPI master.

---
 rtl/a2d_sched.sv | 187 ++++++++++++++++++
 tb/tb_a2d_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin arbiter sequencing two-frame A2D conversions on the shared SPI master
module a2d_sched #(
    parameter logic [2:0] CH0        = 3'd0,
    parameter logic [2:0] CH1        = 3'd1,
    parameter logic [2:0] CH2        = 3'd4,
    parameter logic [2:0] CH3        = 3'd5,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        clr_err,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] res0,
    output logic [11:0] res1,
    output logic [11:0] res2,
    output logic [11:0] res3,
    output logic [3:0]  vld,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_WAIT1,
        S_CMD2,
        S_WAIT2,
        S_ABORT,
        S_GAP
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        pending_q, pending_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [3:0][11:0]  res_q, res_d;
    logic [3:0]        vld_q, vld_d;
    logic              err_q, err_d;
    logic [15:0]       wait_q, wait_d;
    logic [7:0]        gap_q, gap_d;

    logic [3:0]        clr_mask;
    logic [1:0]        arb_idx;
    logic [1:0]        cand;
    logic              arb_found;
    logic              unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:12];

    function automatic logic [2:0] ch_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    ch_sel = CH0;
            2'd1:    ch_sel = CH1;
            2'd2:    ch_sel = CH2;
            default: ch_sel = CH3;
        endcase
    endfunction

    // Scan starts one past the last grant so the previous winner is considered last.
    always_comb begin
        arb_idx   = gnt_q;
        arb_found = 1'b0;
        cand      = gnt_q;
        for (int i = 1; i <= 4; i++) begin
            cand = gnt_q + 2'(i);
            if (!arb_found && pending_q[cand]) begin
                arb_idx   = cand;
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cmd_d    = cmd_q;
        res_d    = res_q;
        vld_d    = 4'b0000;
        wait_d   = wait_q;
        gap_d    = gap_q;
        clr_mask = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_idx;
                    cmd_d   = {2'b00, ch_sel(arb_idx), 11'h000};
                    state_d = S_CMD1;
                end
            end
            S_CMD1: begin
                wait_d  = 16'd0;
                state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (done) begin
                    state_d = S_CMD2;
                end else if (wait_q == TO_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_CMD2: begin
                wait_d  = 16'd0;
                state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (done) begin
                    res_d[gnt_q]    = rd_data[11:0];
                    vld_d[gnt_q]    = 1'b1;
                    clr_mask[gnt_q] = 1'b1;
                    gap_d           = 8'd0;
                    state_d         = S_GAP;
                end else if (wait_q == TO_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_ABORT: begin
                clr_mask[gnt_q] = 1'b1;
                gap_d           = 8'd0;
                state_d         = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request arriving on the clearing edge re-arms the bit.
        pending_d = (pending_q & ~clr_mask) | req;

        err_d = clr_err ? 1'b0 : err_q;
        if (state_q == S_ABORT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 4'b0000;
            gnt_q     <= 2'd3;
            cmd_q     <= 16'h0000;
            res_q     <= '0;
            vld_q     <= 4'b0000;
            err_q     <= 1'b0;
            wait_q    <= 16'd0;
            gap_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            gnt_q     <= gnt_d;
            cmd_q     <= cmd_d;
            res_q     <= res_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            gap_q     <= gap_d;
        end
    end

    assign wrt  = (state_q == S_CMD1) || (state_q == S_CMD2);
    assign busy = (state_q != S_IDLE);
    assign cmd  = cmd_q;
    assign vld  = vld_q;
    assign err  = err_q;
    assign res0 = res_q[0];
    assign res1 = res_q[1];
    assign res2 = res_q[2];
    assign res3 = res_q[3];

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - directed self-checking bench for a2d_sched with a simple SPI master model
module tb_a2d_sched;

    localparam int GAP = 4;
    localparam int TO  = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        clr_err;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic        done_mdl;
    logic        done_man;
    logic [15:0] rd_data;
    logic [11:0] res0, res1, res2, res3;
    logic [3:0]  vld;
    logic        busy;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic        mdl_en;
    logic        mdl_hold;
    logic        second;
    logic [15:0] mdl_rd [8];

    int          w_cnt;
    logic [15:0] w_cmd [2];
    logic [3:0]  v_seen;
    int          v_cyc;
    logic        timed_out;

    assign done = done_mdl | done_man;

    a2d_sched #(
        .CH0(3'd0), .CH1(3'd1), .CH2(3'd4), .CH3(3'd5),
        .GAP_CYCLES(GAP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .clr_err(clr_err),
        .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3),
        .vld(vld), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model: answers each frame two cycles after its wrt, optionally withholding the read frame.
    initial begin
        done_mdl = 1'b0;
        rd_data  = 16'h0000;
        second   = 1'b0;
        forever begin
            @(negedge clk);
            done_mdl = 1'b0;
            if (rst) begin
                second = 1'b0;
            end else if (mdl_en && wrt) begin
                repeat (2) @(negedge clk);
                if (!(mdl_hold && second)) begin
                    done_mdl = 1'b1;
                    rd_data  = mdl_rd[cmd[13:11]];
                end
                second = !second;
            end
        end
    end

    task automatic watch_conv(input int max_cyc);
        w_cnt     = 0;
        w_cmd[0]  = 16'hxxxx;
        w_cmd[1]  = 16'hxxxx;
        v_seen    = 4'b0000;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (wrt) begin
                if (w_cnt < 2) w_cmd[w_cnt] = cmd;
                w_cnt++;
            end
            if (vld != 4'b0000) begin
                v_seen    = vld;
                v_cyc     = cyc;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_chk++; if (wrt !== 1'b0) begin n_fail++; $display("FAIL reset_wrt: got %0b want 0", wrt); end
        n_chk++; if (vld !== 4'b0000) begin n_fail++; $display("FAIL reset_vld: got %b want 0000", vld); end
        n_chk++; if (cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
        n_chk++; if ({res0, res1, res2, res3} !== 48'h0) begin
            n_fail++; $display("FAIL reset_res: got %h %h %h %h want all 0", res0, res1, res2, res3);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        n_chk++; if (wrt !== 1'b0) begin n_fail++; $display("FAIL single_lat_early: wrt got %0b want 0", wrt); end
        @(negedge clk);
        n_chk++; if (wrt !== 1'b1) begin n_fail++; $display("FAIL single_lat_wrt: wrt got %0b want 1", wrt); end
        n_chk++; if (cmd !== 16'h0800) begin n_fail++; $display("FAIL single_cmd1: got %h want 0800", cmd); end
        watch_conv(60);
        n_chk++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL single_vld_timeout: got %0b want 0", timed_out); end
        n_chk++; if (w_cnt != 1) begin n_fail++; $display("FAIL single_wrt2_count: got %0d want 1", w_cnt); end
        n_chk++; if (w_cmd[0] !== 16'h0800) begin n_fail++; $display("FAIL single_cmd2: got %h want 0800", w_cmd[0]); end
        n_chk++; if (v_seen !== 4'b0010) begin n_fail++; $display("FAIL single_vld: got %b want 0010", v_seen); end
        n_chk++; if (res1 !== 12'hABC) begin n_fail++; $display("FAIL single_res1: got %h want abc", res1); end
        n_chk++; if ({res0, res2, res3} !== 36'h0) begin
            n_fail++; $display("FAIL single_others: got %h %h %h want 0", res0, res2, res3);
        end
        @(negedge clk);
        n_chk++; if (vld !== 4'b0000) begin n_fail++; $display("FAIL single_vld_width: got %b want 0000", vld); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_cmd [4];
        logic [11:0] exp_res [4];
        logic [11:0] r;
        int          prev;
        int          g;
        exp_cmd[0] = 16'h0000; exp_cmd[1] = 16'h0800; exp_cmd[2] = 16'h2000; exp_cmd[3] = 16'h2800;
        exp_res[0] = 12'h123;  exp_res[1] = 12'hABC;  exp_res[2] = 12'h456;  exp_res[3] = 12'h789;
        do_reset();
        req  = 4'b1111;
        prev = -1;
        for (int i = 0; i < 14; i++) begin
            g = i % 4;
            watch_conv(60);
            if (i == 9) req = 4'b0000;
            case (g)
                0:       r = res0;
                1:       r = res1;
                2:       r = res2;
                default: r = res3;
            endcase
            n_chk++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rr_timeout[%0d]: got %0b want 0", i, timed_out); end
            n_chk++; if (v_seen !== 4'(1 << g)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, v_seen, 4'(1 << g)); end
            n_chk++; if (w_cnt != 2) begin n_fail++; $display("FAIL rr_wrt_count[%0d]: got %0d want 2", i, w_cnt); end
            n_chk++; if (w_cmd[0] !== exp_cmd[g] || w_cmd[1] !== exp_cmd[g]) begin
                n_fail++; $display("FAIL rr_cmd[%0d]: got %h/%h want %h", i, w_cmd[0], w_cmd[1], exp_cmd[g]);
            end
            n_chk++; if (r !== exp_res[g]) begin n_fail++; $display("FAIL rr_res[%0d]: got %h want %h", i, r, exp_res[g]); end
            if (prev >= 0) begin
                n_chk++; if (v_cyc - prev < GAP + 2) begin
                    n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want >= %0d", i, v_cyc - prev, GAP + 2);
                end
            end
            prev = v_cyc;
        end
        watch_conv(30);
        n_chk++; if (timed_out !== 1'b1 || w_cnt != 0) begin
            n_fail++; $display("FAIL rr_drained: vld %b wrt count %0d want none", v_seen, w_cnt);
        end
    endtask

    task automatic test_rerequest();
        @(negedge clk);
        req = 4'b0100;
        watch_conv(60);
        req = 4'b0000;
        n_chk++; if (v_seen !== 4'b0100) begin n_fail++; $display("FAIL rereq_first: got %b want 0100", v_seen); end
        watch_conv(60);
        n_chk++; if (timed_out !== 1'b0 || v_seen !== 4'b0100) begin
            n_fail++; $display("FAIL rereq_second: got vld %b want 0100", v_seen);
        end
        n_chk++; if (w_cmd[0] !== 16'h2000) begin n_fail++; $display("FAIL rereq_cmd: got %h want 2000", w_cmd[0]); end
        watch_conv(30);
        n_chk++; if (timed_out !== 1'b1) begin n_fail++; $display("FAIL rereq_third: got vld %b want none", v_seen); end
    endtask

    task automatic test_timeout();
        int   wc;
        int   w2;
        int   e_cyc;
        logic v_any;
        mdl_hold = 1'b1;
        wc = 0; w2 = -1; e_cyc = -1; v_any = 1'b0;
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (wrt) begin
                wc++;
                if (wc == 2) w2 = cyc;
            end
            if (vld != 4'b0000) v_any = 1'b1;
            if (err) begin
                e_cyc = cyc;
                break;
            end
        end
        mdl_hold = 1'b0;
        n_chk++; if (e_cyc < 0) begin n_fail++; $display("FAIL to_err_set: err never rose, want 1"); end
        n_chk++; if (e_cyc - w2 != TO + 2) begin
            n_fail++; $display("FAIL to_err_time: got %0d cycles after wrt2 want %0d", e_cyc - w2, TO + 2);
        end
        n_chk++; if (v_any !== 1'b0) begin n_fail++; $display("FAIL to_no_vld: got %0b want 0", v_any); end
        n_chk++; if (wc != 2) begin n_fail++; $display("FAIL to_wrt_count: got %0d want 2", wc); end
        n_chk++; if (res3 !== 12'h789) begin n_fail++; $display("FAIL to_res3: got %h want 789", res3); end
        repeat (GAP) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: busy got %0b want 0", busy); end
        watch_conv(20);
        n_chk++; if (timed_out !== 1'b1 || w_cnt != 0) begin
            n_fail++; $display("FAIL to_pending_clr: wrt count %0d want 0", w_cnt);
        end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %0b want 1", err); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_clr_err: got %0b want 0", err); end
    endtask

    task automatic test_reset_mid();
        int hits;
        mdl_en = 1'b0;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            if (wrt) break;
            @(negedge clk);
        end
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_wait1: got %0b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (busy !== 1'b0 || wrt !== 1'b0 || vld !== 4'b0000) begin
            n_fail++; $display("FAIL mid_outputs: busy %0b wrt %0b vld %b want 0", busy, wrt, vld);
        end
        n_chk++; if (cmd !== 16'h0000) begin n_fail++; $display("FAIL mid_cmd: got %h want 0000", cmd); end
        n_chk++; if (res1 !== 12'h000 || res3 !== 12'h000) begin
            n_fail++; $display("FAIL mid_res: res1 %h res3 %h want 0", res1, res3);
        end
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wrt || vld != 4'b0000) hits++;
        end
        n_chk++; if (hits != 0) begin n_fail++; $display("FAIL mid_late_done: got %0d active cycles want 0", hits); end
        mdl_en = 1'b1;
    endtask

    task automatic test_stray_done();
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        n_chk++; if (busy !== 1'b0 || vld !== 4'b0000 || wrt !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: busy %0b vld %b wrt %0b want 0", busy, vld, wrt);
        end
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        watch_conv(60);
        n_chk++; if (v_seen !== 4'b0010) begin n_fail++; $display("FAIL stray_conv: got %b want 0010", v_seen); end
        @(negedge clk);
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        n_chk++; if (vld !== 4'b0000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL stray_gap: vld %b busy %0b want 0000/1", vld, busy);
        end
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stray_gap_last: busy got %0b want 1", busy); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || wrt !== 1'b0) begin
            n_fail++; $display("FAIL stray_back_idle: busy %0b wrt %0b want 0", busy, wrt);
        end
        watch_conv(20);
        n_chk++; if (timed_out !== 1'b1) begin n_fail++; $display("FAIL stray_no_vld: got %b want none", v_seen); end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        clr_err  = 1'b0;
        done_man = 1'b0;
        mdl_en   = 1'b1;
        mdl_hold = 1'b0;
        for (int i = 0; i < 8; i++) mdl_rd[i] = 16'hDEAD;
        mdl_rd[0] = 16'h1123;
        mdl_rd[1] = 16'hFABC;
        mdl_rd[4] = 16'h2456;
        mdl_rd[5] = 16'h3789;

        test_reset();
        test_single();
        test_round_robin();
        test_rerequest();
        test_timeout();
        test_reset_mid();
        test_stray_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
